word_to_byte_serializer: RTL and testbench
==========================================

// Module: word_to_byte_serializer
// PURPOSE
//  Parametrised serializer: accepts one NBYTES*8-bit word per valid/ready handshake and emits it
//  as NBYTES bytes on a byte valid/ready interface toward the UART transmitter. A one-word holding
//  register lets the next word be accepted during serialisation, giving gap-free back-to-back bytes.
//  Byte order is selectable. Word overruns are flagged sticky. Sits between the word source and uart_tx.
// PARAMETERS
//  NBYTES     2   bytes per input word (>=2); word width = 8*NBYTES
//  MSB_FIRST  0   0: send word[7:0] first; 1: send the most significant byte first
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-low reset (0 = reset)
//  ce         in   1          clock enable; 0 freezes all state, forces word_ready=0
//  word_dv    in   1          input word valid
//  word       in   8*NBYTES   input word, sampled on accept
//  word_ready out  1          holding register free; accept = ce & word_dv & word_ready
//  byte_dv    out  1          output byte valid (registered)
//  byte       out  8          current output byte (registered, stable while byte_dv & !byte_ready)
//  byte_last  out  1          byte_dv marks the final byte of a word
//  byte_ready in   1          downstream accepts; transfer = ce & byte_dv & byte_ready
//  ovr        out  1          sticky overrun flag
//  ovr_clr    in   1          synchronous clear of ovr (gated by ce)
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): byte_dv=0, byte=8'h00, byte_last=0, ovr=0, hold empty,
//    shift register and byte counter 0, state IDLE. word_ready=0 while rst=0.
//  - State: IDLE (shifter empty) / SHIFT (shifter holds a word; cnt = bytes already sent, 0..NBYTES-1).
//  - word_ready = ce & !hold_full (combinational from registered hold_full only).
//  - Accept in IDLE: word loaded straight into shifter; next edge -> SHIFT, byte_dv=1, byte = first
//    byte, cnt=0. Latency accept-edge to byte_dv = 1 cycle.
//  - Accept in SHIFT: word stored in hold register, hold_full=1.
//  - Transfer with cnt<NBYTES-1: cnt+1, byte = next byte in the selected order; byte_last=1 iff new
//    cnt==NBYTES-1.
//  - Transfer with cnt==NBYTES-1 (last byte): if hold_full, load hold into shifter, hold_full=0,
//    cnt=0, byte_dv stays 1 (no bubble); else if a word is accepted this same cycle, load it directly
//    (stay SHIFT, no bubble); else byte_dv=0, byte=8'h00, -> IDLE.
//  - No transfer: byte, byte_dv, byte_last, cnt unchanged (AXI-style: byte must not change once valid).
//  - ovr: set when ce & word_dv & !word_ready due to hold_full (word dropped, state untouched);
//    ovr_clr clears; simultaneous set and clear -> set wins.
//  - ce=0: no accept, no transfer, all registers hold; ovr not set.
//  - Byte order: MSB_FIRST=0 -> byte k = word[8k+7:8k]; MSB_FIRST=1 -> byte k = word[8(NBYTES-k)-1 -: 8].
//  - Reset asserted mid-word: word and held word discarded; after release block is IDLE, next word
//    starts at byte 0.
// TESTING
//  1. NBYTES=2, MSB_FIRST=0, byte_ready=1, word=16'hA55A accepted at edge N -> byte 5A (last=0) at
//     N+1, A5 (last=1) at N+2, byte_dv=0 at N+3.
//  2. NBYTES=4, MSB_FIRST=1, word=32'h11223344, byte_ready held 0 for 3 cycles after first byte ->
//     byte stays 11 with byte_dv=1, then 22,33,44 on consecutive ready cycles, last only on 44.
//  3. Back-to-back: 16'h0102 then 16'h0304 with byte_dv/word_dv continuous -> bytes 02,01,04,03 on
//     four consecutive cycles, no byte_dv gap; word_ready low only while hold_full.
//  4. Overrun: byte_ready=0, three words offered -> first in shifter, second in hold, third dropped,
//     ovr=1; ovr_clr pulse -> ovr=0; dropped word never appears on byte.
//  5. ce=0 for 5 cycles mid-word with byte_ready=1 -> no byte advance, word_ready=0, ovr unchanged.
//  6. rst=0 for 1 cycle after first byte of 16'hBEEF -> byte_dv=0, byte=00 immediately; new word
//     16'h1234 -> 34,12.

Source files
------------

// File: rtl/word_to_byte_serializer_if.sv
// Word-in / byte-out handshake bundle for word_to_byte_serializer.
// The 'slave' modport is the serializer's own view; 'master' is the
// environment that supplies words and consumes bytes.
interface word_to_byte_serializer_if #(
  parameter int NBYTES = 2
);
  // Word side
  logic                  word_dv;
  logic [8*NBYTES-1:0]   word;
  logic                  word_ready;
  // Byte side ('byte' is a keyword, so the data lane is byte_data)
  logic                  byte_dv;
  logic [7:0]            byte_data;
  logic                  byte_last;
  logic                  byte_ready;
  // Overrun status
  logic                  ovr;
  logic                  ovr_clr;

  modport master (
    output word_dv, word, byte_ready, ovr_clr,
    input  word_ready, byte_dv, byte_data, byte_last, ovr
  );

  modport slave (
    input  word_dv, word, byte_ready, ovr_clr,
    output word_ready, byte_dv, byte_data, byte_last, ovr
  );
endinterface

// File: rtl/word_to_byte_serializer.sv
// Serialises NBYTES*8-bit words into bytes for the UART transmitter.
// A single holding register accepts the next word while the current one
// is being shifted out, so consecutive words leave with no byte_dv gap.
// Words offered while the holding register is full are dropped and
// flagged on the sticky ovr output.
module word_to_byte_serializer #(
  parameter int NBYTES    = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,   // asynchronous, active low
  input  logic                          ce,
  word_to_byte_serializer_if.slave      bus
);

  localparam int                WORD_W   = 8 * NBYTES;
  localparam int                CNT_W    = $clog2(NBYTES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic {
    IDLE,   // shifter empty, byte_dv low
    SHIFT   // shifter holds a word; cnt = bytes already sent
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic [WORD_W-1:0]  shreg, shreg_n;
  logic [WORD_W-1:0]  hold, hold_n;
  logic               hold_full, hold_full_n;
  logic               byte_dv_q, byte_dv_n;
  logic [7:0]         byte_q, byte_n;
  logic               last_q, last_n;
  logic               ovr_q, ovr_n;

  logic               accept;
  logic               xfer;
  logic               ovr_set;

  // Byte k of a word in the configured transmission order.
  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w,
                                           input logic [CNT_W-1:0]  k);
    int idx;
    idx = MSB_FIRST ? (NBYTES - 1 - int'(k)) : int'(k);
    return w[8*idx +: 8];
  endfunction

  // Ready depends only on registered state; it is forced low in reset and
  // when the clock enable freezes the block.
  assign bus.word_ready = ce & ~hold_full & rst;

  assign accept  = ce & bus.word_dv & bus.word_ready;
  assign xfer    = ce & byte_dv_q & bus.byte_ready;
  assign cnt_inc = cnt + 1'b1;

  // A word arriving while the holding register is occupied is lost.
  assign ovr_set = ce & bus.word_dv & hold_full;

  // Next-state and datapath decode for the shifter / holding register.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can leave
    // one unassigned and infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    byte_dv_n   = byte_dv_q;
    byte_n      = byte_q;
    last_n      = last_q;

    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_n   = bus.word;
          cnt_n     = '0;
          byte_dv_n = 1'b1;
          byte_n    = pick_byte(bus.word, '0);
          last_n    = 1'b0;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (xfer && cnt == LAST_CNT) begin
          if (hold_full) begin
            // Refill from the holding register; byte_dv stays high.
            shreg_n     = hold;
            hold_full_n = 1'b0;
            cnt_n       = '0;
            byte_n      = pick_byte(hold, '0);
            last_n      = 1'b0;
          end else if (accept) begin
            // Word arriving exactly on the last byte goes straight in.
            shreg_n = bus.word;
            cnt_n   = '0;
            byte_n  = pick_byte(bus.word, '0);
            last_n  = 1'b0;
          end else begin
            byte_dv_n = 1'b0;
            byte_n    = 8'h00;
            last_n    = 1'b0;
            cnt_n     = '0;
            state_n   = IDLE;
          end
        end else begin
          if (xfer) begin
            cnt_n  = cnt_inc;
            byte_n = pick_byte(shreg, cnt_inc);
            last_n = (cnt_inc == LAST_CNT);
          end
          if (accept) begin
            hold_n      = bus.word;
            hold_full_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // Sticky overrun: a simultaneous set and clear leaves it set.
  always_comb begin
    ovr_n = ovr_set | (ovr_q & ~(ce & bus.ovr_clr));
  end

  // State register; reset discards both the shifting and the held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      byte_dv_q <= 1'b0;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      byte_dv_q <= byte_dv_n;
      byte_q    <= byte_n;
      last_q    <= last_n;
      ovr_q     <= ovr_n;
    end
  end

  assign bus.byte_dv   = byte_dv_q;
  assign bus.byte_data = byte_q;
  assign bus.byte_last = last_q;
  assign bus.ovr       = ovr_q;

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed bench for word_to_byte_serializer: a 2-byte LSB-first instance
// and a 4-byte MSB-first instance share clock, reset and clock enable.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_word_to_byte_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b1;

  int total = 0;
  int bad   = 0;

  word_to_byte_serializer_if #(.NBYTES(2)) if2 ();
  word_to_byte_serializer_if #(.NBYTES(4)) if4 ();

  word_to_byte_serializer #(.NBYTES(2), .MSB_FIRST(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (if2.slave)
  );

  word_to_byte_serializer #(.NBYTES(4), .MSB_FIRST(1'b1)) dut4 (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (if4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full byte-side state of the 2-byte instance.
  task automatic chk2(input string tag, input logic dv, input logic [7:0] b, input logic last);
    check({tag, ".dv"},   32'(if2.byte_dv),   32'(dv));
    check({tag, ".byte"}, 32'(if2.byte_data), 32'(b));
    check({tag, ".last"}, 32'(if2.byte_last), 32'(last));
  endtask

  task automatic chk4(input string tag, input logic dv, input logic [7:0] b, input logic last);
    check({tag, ".dv"},   32'(if4.byte_dv),   32'(dv));
    check({tag, ".byte"}, 32'(if4.byte_data), 32'(b));
    check({tag, ".last"}, 32'(if4.byte_last), 32'(last));
  endtask

  initial begin
    if2.word_dv = 1'b0; if2.word = '0; if2.byte_ready = 1'b1; if2.ovr_clr = 1'b0;
    if4.word_dv = 1'b0; if4.word = '0; if4.byte_ready = 1'b1; if4.ovr_clr = 1'b0;

    // ---- reset state ----
    step(); step();
    chk2("rst2", 1'b0, 8'h00, 1'b0);
    chk4("rst4", 1'b0, 8'h00, 1'b0);
    check("rst.ovr", 32'(if2.ovr), 32'd0);
    check("rst.word_ready", 32'(if2.word_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rel.word_ready", 32'(if2.word_ready), 32'd1);

    // ---- 1: basic LSB-first word ----
    step();
    if2.word_dv = 1'b1; if2.word = 16'hA55A;
    step();
    if2.word_dv = 1'b0;
    chk2("t1.b0", 1'b1, 8'h5A, 1'b0);
    check("t1.word_ready", 32'(if2.word_ready), 32'd1);
    step();
    chk2("t1.b1", 1'b1, 8'hA5, 1'b1);
    step();
    chk2("t1.end", 1'b0, 8'h00, 1'b0);

    // ---- 2: MSB-first with downstream stall ----
    if4.byte_ready = 1'b0;
    if4.word_dv = 1'b1; if4.word = 32'h11223344;
    step();
    if4.word_dv = 1'b0;
    chk4("t2.b0", 1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk4("t2.stall", 1'b1, 8'h11, 1'b0);
    end
    if4.byte_ready = 1'b1;
    step();
    chk4("t2.b1", 1'b1, 8'h22, 1'b0);
    step();
    chk4("t2.b2", 1'b1, 8'h33, 1'b0);
    step();
    chk4("t2.b3", 1'b1, 8'h44, 1'b1);
    step();
    chk4("t2.end", 1'b0, 8'h00, 1'b0);

    // ---- 3: back-to-back via hold, then direct load on last byte ----
    if2.word_dv = 1'b1; if2.word = 16'h0102;
    step();
    chk2("t3.b0", 1'b1, 8'h02, 1'b0);
    check("t3.rdy0", 32'(if2.word_ready), 32'd1);
    if2.word = 16'h0304;
    step();
    if2.word_dv = 1'b0;
    chk2("t3.b1", 1'b1, 8'h01, 1'b1);
    check("t3.rdy_full", 32'(if2.word_ready), 32'd0);
    step();
    chk2("t3.b2", 1'b1, 8'h04, 1'b0);
    check("t3.rdy_free", 32'(if2.word_ready), 32'd1);
    step();
    chk2("t3.b3", 1'b1, 8'h03, 1'b1);
    if2.word_dv = 1'b1; if2.word = 16'hCAFE;
    step();
    if2.word_dv = 1'b0;
    chk2("t3.direct0", 1'b1, 8'hFE, 1'b0);
    step();
    chk2("t3.direct1", 1'b1, 8'hCA, 1'b1);
    step();
    chk2("t3.end", 1'b0, 8'h00, 1'b0);

    // ---- 4: overrun, set-wins, clear, dropped word never emitted ----
    if2.byte_ready = 1'b0;
    if2.word_dv = 1'b1; if2.word = 16'h0B0A;
    step();
    chk2("t4.b0", 1'b1, 8'h0A, 1'b0);
    if2.word = 16'h0D0C;
    step();
    check("t4.rdy_full", 32'(if2.word_ready), 32'd0);
    check("t4.ovr0", 32'(if2.ovr), 32'd0);
    if2.word = 16'hEEEE;
    step();
    check("t4.ovr_set", 32'(if2.ovr), 32'd1);
    if2.ovr_clr = 1'b1;
    step();
    check("t4.set_wins", 32'(if2.ovr), 32'd1);
    if2.word_dv = 1'b0;
    step();
    check("t4.cleared", 32'(if2.ovr), 32'd0);
    if2.ovr_clr = 1'b0;
    chk2("t4.stalled", 1'b1, 8'h0A, 1'b0);
    if2.byte_ready = 1'b1;
    step();
    chk2("t4.b1", 1'b1, 8'h0B, 1'b1);
    step();
    chk2("t4.b2", 1'b1, 8'h0C, 1'b0);
    step();
    chk2("t4.b3", 1'b1, 8'h0D, 1'b1);
    step();
    chk2("t4.end", 1'b0, 8'h00, 1'b0);

    // ---- 5: clock enable freeze mid-word ----
    if2.word_dv = 1'b1; if2.word = 16'h5566;
    step();
    chk2("t5.b0", 1'b1, 8'h66, 1'b0);
    if2.word = 16'h7788;      // still offered while frozen: must not be taken
    ce = 1'b0;
    #1;
    check("t5.rdy_ce0", 32'(if2.word_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk2("t5.frozen", 1'b1, 8'h66, 1'b0);
      check("t5.ovr", 32'(if2.ovr), 32'd0);
    end
    if2.word_dv = 1'b0;
    ce = 1'b1;
    step();
    chk2("t5.b1", 1'b1, 8'h55, 1'b1);
    step();
    chk2("t5.end", 1'b0, 8'h00, 1'b0);

    // ---- 6: reset mid-word discards shifter and hold ----
    if2.byte_ready = 1'b0;
    if2.word_dv = 1'b1; if2.word = 16'hBEEF;
    step();
    chk2("t6.b0", 1'b1, 8'hEF, 1'b0);
    if2.word = 16'h0BAD;
    step();
    if2.word_dv = 1'b0;
    rst = 1'b0;
    #1;
    chk2("t6.async", 1'b0, 8'h00, 1'b0);
    step();
    rst = 1'b1;
    if2.byte_ready = 1'b1;
    #1;
    check("t6.hold_empty", 32'(if2.word_ready), 32'd1);
    if2.word_dv = 1'b1; if2.word = 16'h1234;
    step();
    if2.word_dv = 1'b0;
    chk2("t6.n0", 1'b1, 8'h34, 1'b0);
    step();
    chk2("t6.n1", 1'b1, 8'h12, 1'b1);
    step();
    chk2("t6.end", 1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
